// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Registered ALU with valid/ready handshake and a bit-serial shifter
//            (one bit per cycle) for SLL/SRL.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] shift_next;
    logic [4:0]       count;
    logic [4:0]       shift_amt;
    logic             shift_left;
    logic             is_shift;
    logic             start_shift;
    logic             accept;
    logic             slt_bit;

    assign shift_amt   = src_b[4:0];
    assign is_shift    = (alu_control == OP_SLL) || (alu_control == OP_SRL);
    assign start_shift = is_shift && (shift_amt != 5'd0);
    assign accept      = in_valid && in_ready;
    assign slt_bit     = $signed(src_a) < $signed(src_b);

    // Shift codes fall through to src_a: that is the correct result for a zero amount.
    always_comb begin
        alu_out = src_a;
        unique case (alu_control)
            OP_ADD:  alu_out = src_a + src_b;
            OP_SUB:  alu_out = src_a - src_b;
            OP_AND:  alu_out = src_a & src_b;
            OP_OR:   alu_out = src_a | src_b;
            OP_XOR:  alu_out = src_a ^ src_b;
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLL:  alu_out = src_a;
            OP_SRL:  alu_out = src_a;
            default: alu_out = src_a;
        endcase
    end

    assign shift_next = shift_left ? {work[WIDTH-2:0], 1'b0}
                                   : {1'b0, work[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    next_state = start_shift ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (count == 5'd1) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        next_state = start_shift ? ST_SHIFT : ST_DONE;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
        out_valid = (state == ST_DONE);
        busy      = (state == ST_SHIFT);
    end

    // Shifts run in a private working register so result/zero only move once, at the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result     <= '0;
            zero       <= 1'b0;
            work       <= '0;
            count      <= 5'd0;
            shift_left <= 1'b0;
        end else if (accept) begin
            if (start_shift) begin
                work       <= src_a;
                count      <= shift_amt;
                shift_left <= (alu_control == OP_SLL);
            end else begin
                result <= alu_out;
                zero   <= (alu_out == '0);
                count  <= 5'd0;
            end
        end else if (state == ST_SHIFT) begin
            work  <= shift_next;
            count <= count - 5'd1;
            if (count == 5'd1) begin
                result <= shift_next;
                zero   <= (shift_next == '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Directed vector table plus hand sequences for alu_exec_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  alu_control = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int checks = 0;
    int failures = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v, input int idx);
        int lat;
        int nbusy;
        @(negedge clk);
        in_valid = 1'b1; alu_control = v.c; src_a = v.a; src_b = v.b; out_ready = 1'b1;
        #1;
        chk($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; src_a = $urandom; src_b = $urandom; alu_control = 3'($urandom);
        lat = 0;
        nbusy = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (busy) nbusy++;
        end
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d busy_cycles", idx), nbusy, v.lat - 1);
        chk($sformatf("v%0d result", idx), result, v.r);
        chk($sformatf("v%0d zero", idx), {31'd0, zero}, {31'd0, v.z});
        @(negedge clk);
        chk($sformatf("v%0d retire", idx), {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] xa [4];
        logic [31:0] xb [4];
        logic [31:0] xr [4];
        bit seen;

        vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1};
        vecs[1]  = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1};
        vecs[2]  = '{3'b001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1};
        vecs[3]  = '{3'b000, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1};
        vecs[4]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1};
        vecs[5]  = '{3'b011, 32'h0000F000, 32'h0000000F, 32'h0000F00F, 1'b0, 1};
        vecs[6]  = '{3'b100, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0, 1};
        vecs[7]  = '{3'b100, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h00000000, 1'b1, 1};
        vecs[8]  = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1};
        vecs[9]  = '{3'b101, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1};
        vecs[10] = '{3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1};
        vecs[11] = '{3'b110, 32'h00000001, 32'h00000004, 32'h00000010, 1'b0, 5};
        vecs[12] = '{3'b111, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 32};
        vecs[13] = '{3'b110, 32'h00000001, 32'h00000000, 32'h00000001, 1'b0, 1};
        vecs[14] = '{3'b111, 32'hF0000000, 32'h00000024, 32'h0F000000, 1'b0, 5};
        vecs[15] = '{3'b110, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 2};
        vecs[16] = '{3'b111, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 2};

        xa = '{32'h00000001, 32'h0000FF00, 32'hFFFFFFFF, 32'h12345678};
        xb = '{32'h00000003, 32'h00000F0F, 32'hFFFFFFFF, 32'h87654321};
        xr = '{32'h00000002, 32'h0000F00F, 32'h00000000, 32'h95511559};

        // Reset state, observed before any clock edge has occurred.
        #2 rst_n = 1'b0;
        #1;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst zero", {31'd0, zero}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            do_op(vecs[i], i);
        end

        // Stall in DONE, then retire and accept in the same edge.
        @(negedge clk);
        in_valid = 1'b1; alu_control = 3'b000; src_a = 32'd1; src_b = 32'd2; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0; src_a = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d out_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("hold%0d result", k), result, 32'd3);
            chk($sformatf("hold%0d in_ready", k), {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        chk("hold3 result", result, 32'd3);
        out_ready = 1'b1; in_valid = 1'b1; alu_control = 3'b011; src_a = 32'hF0; src_b = 32'h0F;
        #1;
        chk("b2b in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("b2b out_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b result", result, 32'h000000FF);
        chk("b2b zero", {31'd0, zero}, 32'd0);
        @(negedge clk);
        chk("b2b retire", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        in_valid = 1'b1; alu_control = 3'b110; src_a = 32'd1; src_b = 32'd20;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid busy", {31'd0, busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid rst busy", {31'd0, busy}, 32'd0);
        chk("mid rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid rst result", result, 32'd0);
        chk("mid rst zero", {31'd0, zero}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        chk("post rst idle", {31'd0, seen}, 32'd0);

        // Four XORs streamed back to back.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1; alu_control = 3'b100; src_a = xa[k]; src_b = xb[k]; out_ready = 1'b1;
            #1;
            chk($sformatf("xor%0d in_ready", k), {31'd0, in_ready}, 32'd1);
            if (k > 0) begin
                chk($sformatf("xor%0d out_valid", k - 1), {31'd0, out_valid}, 32'd1);
                chk($sformatf("xor%0d result", k - 1), result, xr[k - 1]);
            end
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("xor3 out_valid", {31'd0, out_valid}, 32'd1);
        chk("xor3 result", result, xr[3]);
        @(negedge clk);
        chk("xor retire", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the operation request is valid.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept a request this cycle.
REQ-006 The block SHALL have port alu_control, input, 3, the ALU control code from the control unit's ALU decoder.
REQ-007 The block SHALL have port src_a, input, WIDTH, the first operand.
REQ-008 The block SHALL have port src_b, input, WIDTH, the second operand (shift amount in bits [4:0] for shifts).
REQ-009 The block SHALL have port out_valid, output, 1, meaning result and zero are valid.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-011 The block SHALL have port result, output, WIDTH, the registered operation result.
REQ-012 The block SHALL have port zero, output, 1, the registered flag (result == 0).
REQ-013 The block SHALL have port busy, output, 1, high while in state SHIFT.

Function
REQ-014 Codes SHALL be: 000 ADD a+b; 001 SUB a-b; 010 AND; 011 OR; 100 XOR; 101 SLT (signed a<b -> 1, else 0); 110 SLL a<<b[4:0]; 111 SRL logical a>>b[4:0].
REQ-015 ADD and SUB SHALL wrap modulo 2^WIDTH; carry/overflow discarded.
REQ-016 The FSM SHALL have states IDLE, SHIFT, DONE; reset state IDLE.
REQ-017 A request SHALL be accepted on a rising edge where in_valid && in_ready; alu_control, src_a, src_b are sampled only then.
REQ-018 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready), combinationally.
REQ-019 Accepting codes 000-101 SHALL load result/zero and enter DONE: out_valid high the cycle after acceptance (latency 1).
REQ-020 Accepting a shift with amount 0 SHALL load result=src_a and enter DONE (latency 1).
REQ-021 Accepting a shift with amount n>=1 SHALL load the working register with src_a, counter with n, enter SHIFT; each SHIFT cycle shifts one bit and decrements counter; the cycle counter goes 1->0 SHALL enter DONE; out_valid high n+1 cycles after acceptance.
REQ-022 SLL SHALL fill with 0 from the LSB; SRL SHALL fill with 0 from the MSB.
REQ-023 In SHIFT, in_ready SHALL be 0 and out_valid 0; in_valid is ignored.
REQ-024 In DONE, out_valid SHALL be 1 and result/zero SHALL hold stable until out_ready is sampled high.
REQ-025 DONE with out_ready=1 and no new request SHALL go to IDLE with out_valid 0 next cycle.
REQ-026 DONE with out_ready=1 and in_valid=1 SHALL retire the old result and accept the new request in the same edge (back-to-back, one result per cycle for non-shift ops).
REQ-027 zero SHALL be computed from the final result only, updated in the same edge result reaches its final value.
REQ-028 In IDLE, out_valid SHALL be 0; out_ready SHALL be ignored.

Reset
REQ-029 rst_n low SHALL immediately, without clk, force state IDLE, out_valid 0, busy 0, result 0, zero 0, shift counter 0.
REQ-030 Reset during SHIFT or DONE SHALL abandon the operation; no result is produced after rst_n releases.
REQ-031 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 ADD 0xFFFFFFFF+0x00000001, out_ready=1 -> out_valid next cycle, result 0x00000000, zero 1.
REQ-033 SLT a=0xFFFFFFFF(-1), b=0x00000001 -> result 0x00000001, zero 0; SUB 5-5 -> result 0, zero 1.
REQ-034 SLL a=0x00000001, b=0x00000004 -> busy 4 cycles, out_valid exactly 5 cycles after acceptance, result 0x00000010; SRL 0x80000000 by 31 -> 0x00000001 after 32 cycles.
REQ-035 Hold out_ready=0 for 3 cycles in DONE -> result stable, in_ready 0; then out_ready=1 with in_valid=1 (OR 0xF0|0x0F) -> next cycle result 0x000000FF.
REQ-036 Assert rst_n=0 mid-SHIFT (SLL by 20, after 5 cycles) -> outputs zero immediately without clock edge; after release out_valid stays 0 until a new request.
REQ-037 Stream 4 back-to-back XOR requests with out_ready=1 -> in_ready constantly 1, one result per cycle, in order.
